// File: rtl/board_pkg.sv
// Shared types, grid geometry and lookup helpers for the board tile store.
// The auto-hide timeout is built only when BOARD_REVEAL_TIMEOUT_EN is defined.
package board_pkg;

  typedef enum logic [3:0] {
    TILE_RED, TILE_ORANGE, TILE_YELLOW, TILE_LIME, TILE_GREEN, TILE_TEAL,
    TILE_CYAN, TILE_BLUE, TILE_PURPLE, TILE_PINK, TILE_BROWN, TILE_GRAY
  } tile_e;

  typedef enum logic [1:0] {
    KIND_NONE     = 2'd0,
    KIND_TRACK    = 2'd1,
    KIND_HIDDEN   = 2'd2,
    KIND_REVEALED = 2'd3
  } kind_e;

  typedef enum logic [1:0] {READY, LOAD, SHUF, FLIP} state_e;

  localparam logic [2:0] ROW_MIN   = 3'd1;
  localparam logic [2:0] ROW_MAX   = 3'd6;
  localparam logic [3:0] COL_MIN   = 4'd1;
  localparam logic [3:0] COL_MAX   = 4'd8;
  localparam logic [2:0] CARD_ROW0 = 3'd3;
  localparam logic [3:0] CARD_COL0 = 4'd2;
  localparam logic [3:0] CARD_COL1 = 4'd7;

  localparam int         NUM_CARDS = 12;
  localparam logic [3:0] CARD_LAST = 4'd11;
  localparam logic [3:0] CARD_NONE = 4'hF;
  localparam logic [4:0] NUM_TRACK = 5'd24;
  localparam logic [4:0] RING_NONE = 5'h1F;

  // Right-shifting Galois form of x^8 + x^6 + x^5 + x^4 + 1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Clockwise perimeter walk starting at (1,1); RING_NONE when off the ring.
  function automatic logic [4:0] ring_index(input logic [2:0] row, input logic [3:0] col);
    logic [4:0] idx;
    idx = RING_NONE;
    if (row == ROW_MIN && col >= COL_MIN && col <= COL_MAX)
      idx = {1'b0, col} - 5'd1;
    else if (col == COL_MAX && row > ROW_MIN && row <= ROW_MAX)
      idx = {2'b00, row} + 5'd6;
    else if (row == ROW_MAX && col >= COL_MIN && col < COL_MAX)
      idx = 5'd20 - {1'b0, col};
    else if (col == COL_MIN && row > ROW_MIN && row < ROW_MAX)
      idx = 5'd25 - {2'b00, row};
    return idx;
  endfunction

  function automatic logic [3:0] track_code(input logic [4:0] ring);
    logic [4:0] code;
    code = (ring >= (NUM_TRACK >> 1)) ? ring - (NUM_TRACK >> 1) : ring;
    return code[3:0];
  endfunction

  function automatic logic [3:0] card_index(input logic [2:0] row, input logic [3:0] col);
    logic [3:0] idx;
    idx = CARD_NONE;
    if ((row == CARD_ROW0 || row == CARD_ROW0 + 3'd1) && col >= CARD_COL0 && col <= CARD_COL1)
      idx = ((row == CARD_ROW0) ? 4'd0 : 4'd6) + (col - CARD_COL0);
    return idx;
  endfunction

endpackage

// File: rtl/board_tile_store_if.sv
// Game-FSM and renderer connection to the board tile store.
interface board_tile_store_if;
  logic       init_start;
  logic       init_busy;
  logic       flip_valid;
  logic [3:0] flip_idx;
  logic       flip_ready;
  logic       flip_done;
  logic [3:0] flip_code;
  logic       hide_all;
  logic [2:0] rd_row;
  logic [3:0] rd_col;
  logic [3:0] rd_code;
  logic [1:0] rd_kind;

  modport master (
    output init_start, flip_valid, flip_idx, hide_all, rd_row, rd_col,
    input  init_busy, flip_ready, flip_done, flip_code, rd_code, rd_kind
  );

  modport slave (
    input  init_start, flip_valid, flip_idx, hide_all, rd_row, rd_col,
    output init_busy, flip_ready, flip_done, flip_code, rd_code, rd_kind
  );
endinterface

// File: rtl/board_lfsr.sv
// 8-bit Galois LFSR (taps 8,6,5,4) with seed load on reset and advance enable.
module board_lfsr
  import board_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [7:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= SEED;
    else if (advance)
      value <= {1'b0, value[7:1]} ^ (value[0] ? LFSR_TAPS : 8'h00);
  end

endmodule

// File: rtl/board_tile_store.sv
// Board tile state: fixed track ring, 12 shuffled centre cards, flip/hide control, 1-cycle read port.
// Optional auto-hide timeout is enabled by defining BOARD_REVEAL_TIMEOUT_EN.
module board_tile_store
  import board_pkg::*;
#(
  parameter logic [7:0]  LFSR_SEED     = 8'hA5,
  parameter logic [23:0] REVEAL_CYCLES = 24'd10_000_000
) (
  input logic               clk,
  input logic               rst,
  board_tile_store_if.slave tile
);

  state_e               state, state_next;
  logic [3:0]           card_code [NUM_CARDS];
  logic [NUM_CARDS-1:0] revealed;
  logic [3:0]           shuf_i;
  logic [3:0]           flip_sel;
  logic [7:0]           lfsr;
  logic [3:0]           shuf_j;
  logic                 swap_ok;
  logic                 flip_accept;
  logic                 timeout_clear;
  logic                 unused_lfsr_hi;

  board_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (state == SHUF),
    .value   (lfsr)
  );

  assign shuf_j         = lfsr[3:0];
  assign unused_lfsr_hi = ^lfsr[7:4];
  assign swap_ok        = (shuf_j <= shuf_i);
  // Init has priority; out-of-range indices are consumed without effect.
  assign flip_accept    = (state == READY) && !tile.init_start && tile.flip_valid
                          && (tile.flip_idx <= CARD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= READY;
    else     state <= state_next;
  end

  // NOTE: assigning a default before the case keeps this block purely combinational (no latch).
  always_comb begin
    state_next = state;
    case (state)
      READY: if (tile.init_start) state_next = LOAD;
             else if (flip_accept) state_next = FLIP;
      LOAD:  state_next = SHUF;
      SHUF:  if (swap_ok && shuf_i == 4'd1) state_next = READY;
      FLIP:  state_next = READY;
      default: state_next = READY;
    endcase
  end

  assign tile.init_busy  = (state == LOAD) || (state == SHUF);
  assign tile.flip_ready = (state == READY);
  assign tile.flip_done  = (state == FLIP);
  assign tile.flip_code  = (state == FLIP) ? card_code[flip_sel] : 4'd0;

  // NOTE: the card array is reset because the identity order is architecturally visible after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CARDS; k++) card_code[k] <= 4'(k);
      revealed <= '0;
      shuf_i   <= '0;
      flip_sel <= '0;
    end else begin
      if (flip_accept) flip_sel <= tile.flip_idx;
      case (state)
        LOAD: begin
          for (int k = 0; k < NUM_CARDS; k++) card_code[k] <= 4'(k);
          shuf_i <= CARD_LAST;
        end
        SHUF: if (swap_ok) begin
          card_code[shuf_i] <= card_code[shuf_j];
          card_code[shuf_j] <= card_code[shuf_i];
          shuf_i            <= shuf_i - 4'd1;
        end
        default: ;
      endcase
      if (tile.hide_all || state == LOAD || timeout_clear) revealed <= '0;
      // Later assignment wins, so a flip survives a coincident hide_all.
      if (state == FLIP) revealed[flip_sel] <= 1'b1;
    end
  end

`ifdef BOARD_REVEAL_TIMEOUT_EN
  logic [23:0] reveal_cnt;
  logic        reveal_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reveal_cnt <= '0;
      reveal_run <= 1'b0;
    end else if (state == FLIP) begin
      reveal_cnt <= REVEAL_CYCLES;
      reveal_run <= 1'b1;
    end else if (tile.init_start || tile.hide_all) begin
      reveal_run <= 1'b0;
    end else if (reveal_run && state == READY) begin
      if (reveal_cnt == 24'd0) reveal_run <= 1'b0;
      else                     reveal_cnt <= reveal_cnt - 24'd1;
    end
  end

  assign timeout_clear = reveal_run && (state == READY) && (reveal_cnt == 24'd0);
`else
  logic unused_reveal_cycles;
  assign unused_reveal_cycles = ^REVEAL_CYCLES;
  assign timeout_clear        = 1'b0;
`endif

  kind_e      look_kind;
  logic [3:0] look_code;
  logic [4:0] ring_idx;
  logic [3:0] card_idx;
  logic [3:0] rd_code_q;
  kind_e      rd_kind_q;

  always_comb begin
    look_kind = KIND_NONE;
    look_code = 4'd0;
    ring_idx  = ring_index(tile.rd_row, tile.rd_col);
    card_idx  = card_index(tile.rd_row, tile.rd_col);
    if (ring_idx != RING_NONE) begin
      look_kind = KIND_TRACK;
      look_code = track_code(ring_idx);
    end else if (card_idx != CARD_NONE) begin
      look_kind = revealed[card_idx] ? KIND_REVEALED : KIND_HIDDEN;
      look_code = card_code[card_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_code_q <= 4'd0;
      rd_kind_q <= KIND_NONE;
    end else begin
      rd_code_q <= look_code;
      rd_kind_q <= look_kind;
    end
  end

  assign tile.rd_code = rd_code_q;
  assign tile.rd_kind = rd_kind_q;

endmodule

// File: tb/tb_board_tile_store.sv
// Directed self-checking bench for board_tile_store.
module tb_board_tile_store;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  logic [3:0] exp_perm [12];
  logic [3:0] got_code;
  logic [1:0] got_kind;

  board_tile_store_if tile ();

  board_tile_store #(
    .LFSR_SEED     (8'hA5),
    .REVEAL_CYCLES (24'd20)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .tile (tile)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_tile(input logic [2:0] row, input logic [3:0] col);
    tile.rd_row = row;
    tile.rd_col = col;
    step();
    got_code = tile.rd_code;
    got_kind = tile.rd_kind;
  endtask

  task automatic read_check(input string tag, input logic [2:0] row, input logic [3:0] col,
                            input logic [1:0] kind, input logic [3:0] code);
    read_tile(row, col);
    check({tag, " kind"}, 32'(got_kind), 32'(kind));
    check({tag, " code"}, 32'(got_code), 32'(code));
  endtask

  task automatic flip(input logic [3:0] idx, input logic [3:0] code);
    tile.flip_valid = 1'b1;
    tile.flip_idx   = idx;
    step();
    tile.flip_valid = 1'b0;
    check("flip_done pulse", 32'(tile.flip_done), 32'd1);
    check("flip_code", 32'(tile.flip_code), 32'(code));
    step();
    check("flip_done drops", 32'(tile.flip_done), 32'd0);
  endtask

  // Reference Fisher-Yates shuffle driven by the LFSR from the reset seed.
  function automatic void build_expected();
    logic [7:0] l;
    logic [3:0] j, tmp;
    int         i;
    l = 8'hA5;
    i = 11;
    for (int k = 0; k < 12; k++) exp_perm[k] = 4'(k);
    for (int guard = 0; guard < 2000 && i > 0; guard++) begin
      j = l[3:0];
      l = {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
      if (int'(j) <= i) begin
        tmp         = exp_perm[i];
        exp_perm[i] = exp_perm[j];
        exp_perm[j] = tmp;
        i--;
      end
    end
  endfunction

  task automatic run_init(input logic hold_flip);
    int  cycles;
    bit  done_seen;
    tile.init_start = 1'b1;
    step();
    tile.init_start = 1'b0;
    check("init_busy rises", 32'(tile.init_busy), 32'd1);
    check("flip_ready low in init", 32'(tile.flip_ready), 32'd0);
    tile.flip_valid = hold_flip;
    tile.flip_idx   = 4'd2;
    cycles    = 0;
    done_seen = 1'b0;
    while (tile.init_busy && cycles < 600) begin
      if (tile.flip_done || tile.flip_ready) done_seen = 1'b1;
      step();
      cycles++;
    end
    tile.flip_valid = 1'b0;
    check("init finishes within 600", 32'(tile.init_busy), 32'd0);
    check("no flip during init", 32'(done_seen), 32'd0);
  endtask

  task automatic check_shuffle(input string tag);
    logic [11:0] seen;
    seen = '0;
    for (int k = 0; k < 12; k++) begin
      read_tile(3'(3 + k / 6), 4'(2 + k % 6));
      check({tag, " kind"}, 32'(got_kind), 32'd2);
      check({tag, " code"}, 32'(got_code), 32'(exp_perm[k]));
      seen[got_code] = 1'b1;
    end
    check({tag, " permutation"}, 32'(seen), 32'hFFF);
  endtask

  initial begin
    tile.init_start = 1'b0;
    tile.flip_valid = 1'b0;
    tile.flip_idx   = 4'd0;
    tile.hide_all   = 1'b0;
    tile.rd_row     = 3'd0;
    tile.rd_col     = 4'd0;
    build_expected();

    // Reset values
    step();
    step();
    check("rst init_busy", 32'(tile.init_busy), 32'd0);
    check("rst flip_ready", 32'(tile.flip_ready), 32'd1);
    check("rst flip_done", 32'(tile.flip_done), 32'd0);
    check("rst flip_code", 32'(tile.flip_code), 32'd0);
    check("rst rd_code", 32'(tile.rd_code), 32'd0);
    check("rst rd_kind", 32'(tile.rd_kind), 32'd0);
    rst = 1'b0;

    // Track ring corners and off-board cells
    read_check("ring (1,1)", 3'd1, 4'd1, 2'd1, 4'd0);
    read_check("ring (1,8)", 3'd1, 4'd8, 2'd1, 4'd7);
    read_check("ring (6,8)", 3'd6, 4'd8, 2'd1, 4'd0);
    read_check("ring (6,1)", 3'd6, 4'd1, 2'd1, 4'd7);
    read_check("ring (4,1)", 3'd4, 4'd1, 2'd1, 4'd9);
    read_check("ring (3,8)", 3'd3, 4'd8, 2'd1, 4'd9);
    read_check("none (0,0)", 3'd0, 4'd0, 2'd0, 4'd0);
    read_check("none (7,9)", 3'd7, 4'd9, 2'd0, 4'd0);
    read_check("none (2,4)", 3'd2, 4'd4, 2'd0, 4'd0);

    // Identity cards after reset, then reveal card 5
    read_check("card (3,2)", 3'd3, 4'd2, 2'd2, 4'd0);
    read_check("card (4,7)", 3'd4, 4'd7, 2'd2, 4'd11);
    flip(4'd5, 4'd5);
    read_check("revealed (3,7)", 3'd3, 4'd7, 2'd3, 4'd5);

    // Out-of-range index is dropped
    tile.flip_valid = 1'b1;
    tile.flip_idx   = 4'd13;
    step();
    tile.flip_valid = 1'b0;
    check("idx13 no done", 32'(tile.flip_done), 32'd0);
    check("idx13 still ready", 32'(tile.flip_ready), 32'd1);

    // Shuffle from the reset seed, with a flip held during busy
    run_init(1'b1);
    check_shuffle("shuffle1");

    // Same order after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_init(1'b0);
    check_shuffle("shuffle2");

    // Reset in the middle of the shuffle
    tile.init_start = 1'b1;
    step();
    tile.init_start = 1'b0;
    step();
    step();
    step();
    check("mid-shuffle busy", 32'(tile.init_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async rst init_busy", 32'(tile.init_busy), 32'd0);
    check("async rst flip_ready", 32'(tile.flip_ready), 32'd1);
    check("async rst rd_kind", 32'(tile.rd_kind), 32'd0);
    check("async rst rd_code", 32'(tile.rd_code), 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 12; k++)
      read_check("identity", 3'(3 + k / 6), 4'(2 + k % 6), 2'd2, 4'(k));

    // hide_all, and a hide_all coinciding with FLIP
    flip(4'd0, 4'd0);
    read_check("card0 revealed", 3'd3, 4'd2, 2'd3, 4'd0);
    tile.hide_all = 1'b1;
    step();
    tile.hide_all = 1'b0;
    read_check("card0 hidden", 3'd3, 4'd2, 2'd2, 4'd0);
    flip(4'd0, 4'd0);
    tile.flip_valid = 1'b1;
    tile.flip_idx   = 4'd1;
    step();
    tile.flip_valid = 1'b0;
    tile.hide_all   = 1'b1;
    step();
    tile.hide_all   = 1'b0;
    read_check("hide+flip card1", 3'd3, 4'd3, 2'd3, 4'd1);
    read_check("hide+flip card0", 3'd3, 4'd2, 2'd2, 4'd0);
    flip(4'd1, 4'd1);

    // Init wins over a simultaneous flip
    tile.init_start = 1'b1;
    tile.flip_valid = 1'b1;
    tile.flip_idx   = 4'd0;
    step();
    tile.init_start = 1'b0;
    tile.flip_valid = 1'b0;
    check("init over flip busy", 32'(tile.init_busy), 32'd1);
    check("init over flip done", 32'(tile.flip_done), 32'd0);
    for (int c = 0; c < 600 && tile.init_busy; c++) step();
    check("second init ends", 32'(tile.init_busy), 32'd0);

`ifdef BOARD_REVEAL_TIMEOUT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    flip(4'd3, 4'd3);
    read_check("timeout revealed", 3'd3, 4'd5, 2'd3, 4'd3);
    for (int c = 0; c < 22; c++) step();
    read_check("timeout hidden", 3'd3, 4'd5, 2'd2, 4'd3);
    flip(4'd3, 4'd3);
    step();
    tile.hide_all = 1'b1;
    step();
    tile.hide_all = 1'b0;
    read_check("early hide", 3'd3, 4'd5, 2'd2, 4'd3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
